// File: rtl/freq_meter.sv
// Counts synchronized rising edges of sig_in over a GATE_CYCLES window; result held on freq_count/overflow.
// Latency: busy for exactly GATE_CYCLES cycles after start, then freq_valid is held until freq_ack.
module freq_meter #(
  parameter int GATE_CYCLES = 50000,
  parameter int COUNT_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk50MHz,
  input  logic               reset_n,
  input  logic               sig_in,
  input  logic               start,
  input  logic               freq_ack,
  output logic               busy,
  output logic               freq_valid,
  output logic [COUNT_W-1:0] freq_count,
  output logic               overflow
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [GATE_W-1:0]      r_gate_cnt;
  logic [COUNT_W-1:0]     r_edge_cnt;
  logic                   r_sat;
  logic                   r_busy;
  logic                   r_valid;
  logic [COUNT_W-1:0]     r_count;
  logic                   r_ovf;

  logic                   w_sync_out;
  logic                   w_rise;
  logic                   w_cnt_max;
  logic                   w_inc;
  logic [COUNT_W-1:0]     w_next_cnt;
  logic                   w_next_sat;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_rise     = w_sync_out & ~r_prev;
  assign w_cnt_max  = &r_edge_cnt;
  assign w_inc      = w_rise & ~w_cnt_max;
  assign w_next_cnt = r_edge_cnt + {{(COUNT_W-1){1'b0}}, w_inc};
  assign w_next_sat = r_sat | (w_rise & w_cnt_max);

  // The prev flop runs in every state so a level already high at start is not seen as an edge.
  always_ff @(posedge clk50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_prev <= w_sync_out;
    end
  end

  always_ff @(posedge clk50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_MEASURE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_MEASURE: begin
          r_edge_cnt <= w_next_cnt;
          r_sat      <= w_next_sat;
          r_gate_cnt <= r_gate_cnt + 1'b1;
          if (r_gate_cnt == GATE_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_count <= w_next_cnt;
            r_ovf   <= w_next_sat;
          end
        end
        S_DONE: begin
          if (freq_ack) begin
            r_valid <= 1'b0;
            if (start) begin
              r_state    <= S_MEASURE;
              r_gate_cnt <= '0;
              r_edge_cnt <= '0;
              r_sat      <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign freq_valid = r_valid;
  assign freq_count = r_count;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_freq_meter.sv
// Two meters (16-bit and 4-bit result) share all inputs; a sampled-history model predicts each window's count.
module tb_freq_meter;

  localparam int GATE = 100;
  localparam int HMAX = 16384;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sig_in = 1'b0;
  logic        start = 1'b0;
  logic        freq_ack = 1'b0;
  logic        busy, busy4;
  logic        freq_valid, freq_valid4;
  logic [15:0] freq_count;
  logic [3:0]  freq_count4;
  logic        overflow, overflow4;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit hist [0:HMAX-1];

  int mode = 0;
  int period = 10;
  int ph = 0;

  always #10 clk = ~clk;

  freq_meter #(.GATE_CYCLES(GATE), .COUNT_W(16), .SYNC_STAGES(2)) u_dut16 (
    .clk50MHz(clk), .reset_n(reset_n), .sig_in(sig_in), .start(start), .freq_ack(freq_ack),
    .busy(busy), .freq_valid(freq_valid), .freq_count(freq_count), .overflow(overflow)
  );

  freq_meter #(.GATE_CYCLES(GATE), .COUNT_W(4), .SYNC_STAGES(2)) u_dut4 (
    .clk50MHz(clk), .reset_n(reset_n), .sig_in(sig_in), .start(start), .freq_ack(freq_ack),
    .busy(busy4), .freq_valid(freq_valid4), .freq_count(freq_count4), .overflow(overflow4)
  );

  // Record what the synchronizer sees at each edge; a held reset reads as 0.
  always @(posedge clk) begin
    if (cyc < HMAX) hist[cyc] = reset_n ? sig_in : 1'b0;
    cyc = cyc + 1;
  end

  initial begin
    forever begin
      @(negedge clk);
      case (mode)
        0: sig_in = 1'b0;
        1: sig_in = 1'b1;
        2: begin
          sig_in = ((ph % period) < (period / 2));
          ph = ph + 1;
        end
        default: sig_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Edges counted in the window whose start was sampled at edge k:
  // a rise is sig high two samples back and low three samples back.
  function automatic int edges_in_window(input int k);
    int n = 0;
    for (int t = k + 1; t <= k + GATE; t++)
      if (t >= 3 && hist[t-2] && !hist[t-3]) n++;
    return n;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic run_window(input string tag, input bit ack_too, input bit pokes,
                            input int hold, input bit leave_done);
    int k, n, busy_bad, e16, e4;
    start = 1'b1;
    freq_ack = ack_too;
    k = cyc;
    @(negedge clk);
    start = 1'b0;
    freq_ack = 1'b0;
    busy_bad = 0;
    for (int i = 0; i < GATE; i++) begin
      if (!(busy === 1'b1 && busy4 === 1'b1 && freq_valid === 1'b0 && freq_valid4 === 1'b0))
        busy_bad++;
      start    = pokes && (i == 30 || i == 60);
      freq_ack = pokes && (i == 30 || i == 45);
      @(negedge clk);
    end
    start = 1'b0;
    freq_ack = 1'b0;
    chk({tag, ".busy_window"}, busy_bad, 0);
    chk({tag, ".busy_end"}, {busy, busy4}, 2'b00);
    chk({tag, ".valid"}, {freq_valid, freq_valid4}, 2'b11);
    n = edges_in_window(k);
    e16 = (n > 65535) ? 65535 : n;
    e4 = (n > 15) ? 15 : n;
    chk({tag, ".count16"}, freq_count, e16);
    chk({tag, ".ovf16"}, overflow, (n > 65535));
    chk({tag, ".count4"}, freq_count4, e4);
    chk({tag, ".ovf4"}, overflow4, (n > 15));
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        start = (h % 3 == 0);
        @(negedge clk);
      end
      start = 1'b0;
      chk({tag, ".hold_state"}, {busy, freq_valid, busy4, freq_valid4}, 4'b0101);
      chk({tag, ".hold_count16"}, freq_count, e16);
      chk({tag, ".hold_count4"}, {overflow4, freq_count4}, {(n > 15), 4'(e4)});
    end
    if (!leave_done) begin
      freq_ack = 1'b1;
      @(negedge clk);
      freq_ack = 1'b0;
      chk({tag, ".after_ack"}, {busy, freq_valid, busy4, freq_valid4}, 4'b0000);
      chk({tag, ".kept_count"}, freq_count, e16);
    end
  endtask

  initial begin
    idle(4);
    chk("reset.outs16", {busy, freq_valid, overflow, freq_count}, 0);
    chk("reset.outs4", {busy4, freq_valid4, overflow4, freq_count4}, 0);
    reset_n = 1'b1;
    mode = 2;
    period = 10;
    idle(5);

    // Stray ack in IDLE has no effect.
    freq_ack = 1'b1;
    @(negedge clk);
    freq_ack = 1'b0;
    chk("idle_ack", {busy, freq_valid}, 2'b00);

    for (int p = 0; p < 3; p++) begin
      ph = $urandom_range(0, 9);
      idle($urandom_range(1, 7));
      run_window("sq10", 1'b0, 1'b0, 0, 1'b0);
    end

    period = 2;
    run_window("sq2_sat", 1'b0, 1'b0, 0, 1'b0);
    period = 10;
    run_window("sq10_nosat", 1'b0, 1'b0, 0, 1'b0);

    mode = 1;
    idle(10);
    run_window("held_hi", 1'b0, 1'b0, 0, 1'b0);
    mode = 0;
    idle(10);
    run_window("held_lo", 1'b0, 1'b0, 0, 1'b0);

    mode = 3;
    run_window("rand_hold", 1'b0, 1'b1, 20, 1'b1);
    run_window("rand_chain", 1'b1, 1'b0, 0, 1'b0);

    // Abort mid-window: outputs drop asynchronously, nothing partial appears.
    mode = 2;
    period = 10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(50);
    reset_n = 1'b0;
    #1;
    chk("midreset.outs16", {busy, freq_valid, overflow, freq_count}, 0);
    chk("midreset.outs4", {busy4, freq_valid4, overflow4, freq_count4}, 0);
    idle(4);
    reset_n = 1'b1;
    idle(5);
    chk("post_reset", {busy, freq_valid, freq_count}, 0);
    run_window("after_reset", 1'b0, 1'b0, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      period = $urandom_range(2, 25);
      ph = $urandom_range(0, 24);
      idle($urandom_range(1, 9));
      run_window("rand_period", 1'b0, 1'b0, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
